// File: rtl/acq_trigger_ctrl_if.sv
// rtl/acq_trigger_ctrl_if.sv - ADC sample, RAM write and host status bundle for the acquisition scheduler
interface acq_trigger_ctrl_if #(
  parameter int ADC_W = 12,
  parameter int DEPTH = 1024
);
  localparam int AW = $clog2(DEPTH);

  // ADC sample stream (clk domain, one-cycle strobe per sample)
  logic             adc_clk_en;
  logic [ADC_W-1:0] adc_data;

  // Shared sample RAM write port, address is {write_bank, ptr}
  logic             wr_en;
  logic [AW:0]      wr_addr;
  logic [ADC_W-1:0] wr_data;

  // Frame status towards the register block / MCU
  logic             host_busy;
  logic             frame_done;
  logic             rd_bank;
  logic [AW-1:0]    trig_pos;
  logic             forced;
  logic             frame_rdy;

  modport master (
    input  adc_clk_en, adc_data, host_busy,
    output wr_en, wr_addr, wr_data, frame_done, rd_bank, trig_pos, forced, frame_rdy
  );

  modport slave (
    output adc_clk_en, adc_data, host_busy,
    input  wr_en, wr_addr, wr_data, frame_done, rd_bank, trig_pos, forced, frame_rdy
  );
endinterface

// File: rtl/acq_trigger_ctrl.sv
// rtl/acq_trigger_ctrl.sv - ping-pong ADC capture scheduler with hysteresis trigger, auto-timeout and holdoff
module acq_trigger_ctrl #(
  parameter int ADC_W  = 12,
  parameter int DEPTH  = 1024,
  parameter int TMO_W  = 24,
  parameter int HOLD_W = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  acq_trigger_ctrl_if.master bus,
  input  logic [1:0]        cfg_mode,
  input  logic              cfg_edge,
  input  logic [ADC_W-1:0]  cfg_level,
  input  logic [7:0]        cfg_hyst,
  input  logic [AW-1:0]     cfg_pretrig,
  input  logic [TMO_W-1:0]  cfg_timeout,
  input  logic [HOLD_W-1:0] cfg_holdoff,
  input  logic              arm,
  output logic [2:0]        state_o
);

  localparam logic [1:0] MODE_AUTO   = 2'd0;
  localparam logic [1:0] MODE_NORMAL = 2'd1;
  localparam logic [1:0] MODE_SINGLE = 2'd2;
  localparam logic [1:0] MODE_STOP   = 2'd3;

  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_V   = (AW+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_SWAP    = 3'd4,
    S_HOLDOFF = 3'd5
  } state_t;

  state_t state, next_state;

  // Frame configuration, captured whenever a new frame starts
  logic              lat_edge;
  logic [ADC_W-1:0]  lat_level;
  logic [7:0]        lat_hyst;
  logic [AW-1:0]     lat_pretrig;
  logic [TMO_W-1:0]  lat_timeout;
  logic [HOLD_W-1:0] lat_holdoff;

  // Frame progress
  logic [AW-1:0]     ptr;
  logic [AW:0]       cnt;
  logic [TMO_W-1:0]  tmo;
  logic [HOLD_W-1:0] hcnt;
  logic              write_bank;
  logic              hyst_flag;
  logic [AW-1:0]     trig_ptr;
  logic              trig_was_forced;
  logic              host_busy_q;

  // Decoded controls from the next-state logic
  logic   start_frame;
  logic   do_write;
  logic   do_trig;
  logic   trig_forced;
  logic   do_swap;
  logic   flag_set;
  logic   hold_step;
  state_t start_state;

  // Derived values
  logic              stop;
  logic [AW:0]       cnt_inc;
  logic [AW:0]       post_len;
  logic [TMO_W-1:0]  tmo_inc;
  logic [HOLD_W-1:0] hcnt_inc;
  logic [ADC_W-1:0]  hyst_ext;
  logic [ADC_W:0]    hi_sum;
  logic [ADC_W-1:0]  band_lo;
  logic [ADC_W-1:0]  band_hi;
  logic              flag_hit;
  logic              level_hit;
  logic              tmo_hit;

  assign state_o  = state;
  assign stop     = (cfg_mode == MODE_STOP);
  assign cnt_inc  = cnt + ONE_V;
  // Pretrig is at most DEPTH-1 by port width, so post is always 1..DEPTH
  assign post_len = DEPTH_V - {1'b0, lat_pretrig};
  assign tmo_inc  = tmo + TMO_W'(1);
  assign hcnt_inc = hcnt + HOLD_W'(1);

  // Hysteresis band saturates at 0 and full scale
  assign hyst_ext = ADC_W'(lat_hyst);
  assign hi_sum   = {1'b0, lat_level} + {1'b0, hyst_ext};
  assign band_lo  = (lat_level > hyst_ext) ? (lat_level - hyst_ext) : '0;
  assign band_hi  = hi_sum[ADC_W] ? {ADC_W{1'b1}} : hi_sum[ADC_W-1:0];

  // The flag arms the trigger; it is compared from its registered value, so the
  // sample that sets it can never fire the trigger itself
  assign flag_hit  = lat_edge ? (bus.adc_data > band_hi) : (bus.adc_data < band_lo);
  assign level_hit = hyst_flag &&
                     (lat_edge ? (bus.adc_data <= lat_level) : (bus.adc_data >= lat_level));
  assign tmo_hit   = (cfg_mode == MODE_AUTO) && (lat_timeout != '0) && (tmo_inc == lat_timeout);

  assign start_state = (cfg_pretrig == '0) ? S_ARMED : S_FILL;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and per-cycle datapath controls
  always_comb begin
    next_state  = state;
    start_frame = 1'b0;
    do_write    = 1'b0;
    do_trig     = 1'b0;
    trig_forced = 1'b0;
    do_swap     = 1'b0;
    flag_set    = 1'b0;
    hold_step   = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_mode == MODE_AUTO || cfg_mode == MODE_NORMAL ||
            (cfg_mode == MODE_SINGLE && arm)) begin
          start_frame = 1'b1;
          next_state  = start_state;
        end
      end
      S_FILL: begin
        if (stop) begin
          next_state = S_IDLE;
        end else if (bus.adc_clk_en) begin
          do_write = 1'b1;
          flag_set = flag_hit;
          if (cnt_inc == {1'b0, lat_pretrig}) begin
            next_state = S_ARMED;
          end
        end
      end
      S_ARMED: begin
        if (stop) begin
          next_state = S_IDLE;
        end else if (bus.adc_clk_en) begin
          do_write = 1'b1;
          flag_set = flag_hit;
          if (level_hit || tmo_hit) begin
            do_trig     = 1'b1;
            trig_forced = !level_hit;
            next_state  = (post_len == ONE_V) ? S_SWAP : S_POST;
          end
        end
      end
      S_POST: begin
        if (stop) begin
          next_state = S_IDLE;
        end else if (bus.adc_clk_en) begin
          do_write = 1'b1;
          if (cnt_inc == post_len) begin
            next_state = S_SWAP;
          end
        end
      end
      S_SWAP: begin
        // A completed frame is always published, even if stop is requested
        if (!bus.host_busy) begin
          do_swap    = 1'b1;
          next_state = (cfg_mode == MODE_SINGLE) ? S_IDLE : S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (stop) begin
          next_state = S_IDLE;
        end else if (lat_holdoff == '0 || (bus.adc_clk_en && hcnt_inc == lat_holdoff)) begin
          if (cfg_mode == MODE_SINGLE) begin
            next_state = S_IDLE;
          end else begin
            start_frame = 1'b1;
            next_state  = start_state;
          end
        end else if (bus.adc_clk_en) begin
          hold_step = 1'b1;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Frame datapath: config capture, pointers/counters, RAM write port and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_edge        <= 1'b0;
      lat_level       <= '0;
      lat_hyst        <= '0;
      lat_pretrig     <= '0;
      lat_timeout     <= '0;
      lat_holdoff     <= '0;
      ptr             <= '0;
      cnt             <= '0;
      tmo             <= '0;
      hcnt            <= '0;
      write_bank      <= 1'b0;
      hyst_flag       <= 1'b0;
      trig_ptr        <= '0;
      trig_was_forced <= 1'b0;
      host_busy_q     <= 1'b0;
      bus.wr_en       <= 1'b0;
      bus.wr_addr     <= '0;
      bus.wr_data     <= '0;
      bus.frame_done  <= 1'b0;
      bus.rd_bank     <= 1'b1;
      bus.trig_pos    <= '0;
      bus.forced      <= 1'b0;
      bus.frame_rdy   <= 1'b0;
    end else begin
      host_busy_q    <= bus.host_busy;
      bus.wr_en      <= do_write;
      bus.frame_done <= do_swap;

      if (do_write) begin
        bus.wr_addr <= {write_bank, ptr};
        bus.wr_data <= bus.adc_data;
      end

      if (start_frame) begin
        lat_edge    <= cfg_edge;
        lat_level   <= cfg_level;
        lat_hyst    <= cfg_hyst;
        lat_pretrig <= cfg_pretrig;
        lat_timeout <= cfg_timeout;
        lat_holdoff <= cfg_holdoff;
        ptr         <= '0;
        cnt         <= '0;
        tmo         <= '0;
        hyst_flag   <= 1'b0;
      end else begin
        if (do_write) begin
          ptr <= ptr + 1'b1;
        end
        if (flag_set) begin
          hyst_flag <= 1'b1;
        end
        if (state == S_FILL) begin
          tmo <= '0;
          if (do_write) begin
            cnt <= cnt_inc;
          end
        end
        if (state == S_ARMED && do_write) begin
          tmo <= tmo_inc;
        end
        // Trigger sample is post index 0, so the post count starts at one
        if (do_trig) begin
          cnt             <= ONE_V;
          trig_ptr        <= ptr;
          trig_was_forced <= trig_forced;
        end
        if (state == S_POST && do_write) begin
          cnt <= cnt_inc;
        end
      end

      if (do_swap) begin
        hcnt <= '0;
      end else if (hold_step) begin
        hcnt <= hcnt_inc;
      end

      if (do_swap) begin
        write_bank   <= ~write_bank;
        bus.rd_bank  <= write_bank;
        bus.trig_pos <= trig_ptr;
        bus.forced   <= trig_was_forced;
      end

      // A new frame outranks a simultaneous claim by the MCU
      if (do_swap) begin
        bus.frame_rdy <= 1'b1;
      end else if (bus.host_busy && !host_busy_q) begin
        bus.frame_rdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_acq_trigger_ctrl.sv
// tb/tb_acq_trigger_ctrl.sv - directed scoreboard bench for acq_trigger_ctrl
module tb_acq_trigger_ctrl;
  localparam int ADC_W  = 12;
  localparam int DEPTH  = 1024;
  localparam int TMO_W  = 24;
  localparam int HOLD_W = 16;
  localparam int AW     = 10;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FILL = 3'd1, ST_ARMED = 3'd2,
                         ST_POST = 3'd3, ST_SWAP = 3'd4, ST_HOLD = 3'd5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        cfg_mode = 2'd3;
  logic              cfg_edge = 1'b0;
  logic [ADC_W-1:0]  cfg_level = '0;
  logic [7:0]        cfg_hyst = '0;
  logic [AW-1:0]     cfg_pretrig = '0;
  logic [TMO_W-1:0]  cfg_timeout = '0;
  logic [HOLD_W-1:0] cfg_holdoff = '0;
  logic              arm = 1'b0;
  logic [2:0]        state_o;

  acq_trigger_ctrl_if #(.ADC_W(ADC_W), .DEPTH(DEPTH)) bus ();

  acq_trigger_ctrl #(.ADC_W(ADC_W), .DEPTH(DEPTH), .TMO_W(TMO_W), .HOLD_W(HOLD_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .cfg_mode   (cfg_mode),
    .cfg_edge   (cfg_edge),
    .cfg_level  (cfg_level),
    .cfg_hyst   (cfg_hyst),
    .cfg_pretrig(cfg_pretrig),
    .cfg_timeout(cfg_timeout),
    .cfg_holdoff(cfg_holdoff),
    .arm        (arm),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int fd_cnt = 0;
  logic [22:0]   sbq[$];
  logic          m_bank = 1'b0;
  logic [AW-1:0] m_ptr = '0;

  always @(posedge clk) begin
    if (bus.frame_done) fd_cnt <= fd_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one ADC sample; a write expected from it is queued and compared one clk later
  task automatic sample(input logic [ADC_W-1:0] v, input bit exp_wr);
    logic [22:0] e;
    bus.adc_clk_en = 1'b1;
    bus.adc_data   = v;
    if (exp_wr) begin
      sbq.push_back({m_bank, m_ptr, v});
      m_ptr = m_ptr + 1'b1;
    end
    tick();
    bus.adc_clk_en = 1'b0;
    check("wr_en", {31'd0, bus.wr_en}, {31'd0, exp_wr});
    if (exp_wr) begin
      e = sbq.pop_front();
      check("wr_addr_data", {9'd0, bus.wr_addr, bus.wr_data}, {9'd0, e});
    end
  endtask

  initial begin
    bus.adc_clk_en = 1'b0;
    bus.adc_data   = '0;
    bus.host_busy  = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_state", {29'd0, state_o}, {29'd0, ST_IDLE});
    check("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
    check("rst_rd_bank", {31'd0, bus.rd_bank}, 32'd1);
    check("rst_frame_rdy", {31'd0, bus.frame_rdy}, 32'd0);
    check("rst_trig_pos", {22'd0, bus.trig_pos}, 32'd0);
    rst = 1'b0;
    tick();
    check("stop_idle", {29'd0, state_o}, {29'd0, ST_IDLE});

    // Normal rising trigger on a ramp
    cfg_edge = 1'b0; cfg_level = 12'd2048; cfg_hyst = 8'd16; cfg_pretrig = 10'd100;
    cfg_timeout = '0; cfg_holdoff = 16'd50; cfg_mode = 2'd1;
    tick();
    m_bank = 1'b0; m_ptr = '0;
    check("t1_fill", {29'd0, state_o}, {29'd0, ST_FILL});
    for (int v = 0; v < 2048 + 924; v++) begin
      sample(ADC_W'(v), 1'b1);
      if (v == 99)   check("t1_armed", {29'd0, state_o}, {29'd0, ST_ARMED});
      if (v == 2047) check("t1_no_early_trig", {29'd0, state_o}, {29'd0, ST_ARMED});
      if (v == 2048) check("t1_post", {29'd0, state_o}, {29'd0, ST_POST});
    end
    check("t1_swap", {29'd0, state_o}, {29'd0, ST_SWAP});
    tick();
    check("t1_frame_done", {31'd0, bus.frame_done}, 32'd1);
    check("t1_rd_bank", {31'd0, bus.rd_bank}, 32'd0);
    check("t1_trig_pos", {22'd0, bus.trig_pos}, 32'd0);
    check("t1_forced", {31'd0, bus.forced}, 32'd0);
    check("t1_frame_rdy", {31'd0, bus.frame_rdy}, 32'd1);
    check("t1_holdoff", {29'd0, state_o}, {29'd0, ST_HOLD});
    m_bank = 1'b1;
    for (int i = 0; i < 3; i++) sample(12'd5, 1'b0);
    cfg_mode = 2'd3;
    tick();
    check("t1_stop", {29'd0, state_o}, {29'd0, ST_IDLE});
    check("t1_fd_cnt", fd_cnt, 32'd1);

    // Oscillation inside the hysteresis band never triggers; stop mid-ARMED aborts
    cfg_pretrig = 10'd10; cfg_mode = 2'd1;
    tick();
    m_ptr = '0;
    for (int i = 0; i < 200; i++) sample((i % 2 == 0) ? 12'd2040 : 12'd2050, 1'b1);
    check("t3_still_armed", {29'd0, state_o}, {29'd0, ST_ARMED});
    cfg_mode = 2'd3;
    sample(12'd2040, 1'b0);
    check("t3_abort_idle", {29'd0, state_o}, {29'd0, ST_IDLE});
    tick();
    check("t3_fd_cnt", fd_cnt, 32'd1);
    check("t3_rd_bank", {31'd0, bus.rd_bank}, 32'd0);

    // Auto mode forced trigger, then host_busy stalls the swap
    cfg_pretrig = 10'd100; cfg_timeout = 24'd500; cfg_holdoff = 16'd20; cfg_mode = 2'd0;
    tick();
    m_ptr = '0;
    for (int i = 0; i < 1523; i++) begin
      if (i == 1522) bus.host_busy = 1'b1;
      sample(12'd100, 1'b1);
      if (i == 99)  check("t2_armed", {29'd0, state_o}, {29'd0, ST_ARMED});
      if (i == 598) check("t2_pre_timeout", {29'd0, state_o}, {29'd0, ST_ARMED});
      if (i == 599) check("t2_forced_post", {29'd0, state_o}, {29'd0, ST_POST});
    end
    check("t4_swap_wait", {29'd0, state_o}, {29'd0, ST_SWAP});
    check("t4_rdy_cleared", {31'd0, bus.frame_rdy}, 32'd0);
    for (int i = 0; i < 50; i++) sample(12'd100, 1'b0);
    check("t4_still_swap", {29'd0, state_o}, {29'd0, ST_SWAP});
    check("t4_bank_held", {31'd0, bus.rd_bank}, 32'd0);
    check("t4_no_done", {31'd0, bus.frame_done}, 32'd0);
    bus.host_busy = 1'b0;
    tick();
    check("t4_frame_done", {31'd0, bus.frame_done}, 32'd1);
    check("t4_rd_bank", {31'd0, bus.rd_bank}, 32'd1);
    check("t2_forced", {31'd0, bus.forced}, 32'd1);
    check("t2_trig_pos", {22'd0, bus.trig_pos}, 32'd599);
    check("t4_frame_rdy", {31'd0, bus.frame_rdy}, 32'd1);
    m_bank = 1'b0;
    cfg_mode = 2'd3;
    tick();
    check("t2_stop", {29'd0, state_o}, {29'd0, ST_IDLE});
    check("t2_fd_cnt", fd_cnt, 32'd2);

    // Single shot: waits for arm, ignores arm during POST, returns to IDLE
    cfg_pretrig = 10'd1000; cfg_timeout = '0; cfg_holdoff = '0; cfg_mode = 2'd2;
    repeat (3) tick();
    sample(12'd5, 1'b0);
    check("t5_wait_arm", {29'd0, state_o}, {29'd0, ST_IDLE});
    arm = 1'b1;
    tick();
    arm = 1'b0;
    m_ptr = '0;
    check("t5_fill", {29'd0, state_o}, {29'd0, ST_FILL});
    for (int i = 0; i < 1000; i++) sample(12'd0, 1'b1);
    check("t5_armed", {29'd0, state_o}, {29'd0, ST_ARMED});
    sample(12'd2048, 1'b1);
    check("t5_post", {29'd0, state_o}, {29'd0, ST_POST});
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("t5_arm_ignored", {29'd0, state_o}, {29'd0, ST_POST});
    for (int i = 0; i < 23; i++) sample(ADC_W'(2049 + i), 1'b1);
    check("t5_swap", {29'd0, state_o}, {29'd0, ST_SWAP});
    tick();
    check("t5_frame_done", {31'd0, bus.frame_done}, 32'd1);
    check("t5_rd_bank", {31'd0, bus.rd_bank}, 32'd0);
    check("t5_trig_pos", {22'd0, bus.trig_pos}, 32'd1000);
    check("t5_idle", {29'd0, state_o}, {29'd0, ST_IDLE});
    m_bank = 1'b1;
    for (int i = 0; i < 4; i++) sample(12'd3000, 1'b0);
    check("t5_stays_idle", {29'd0, state_o}, {29'd0, ST_IDLE});
    check("t5_fd_cnt", fd_cnt, 32'd3);

    // Reset mid-POST
    cfg_pretrig = '0; cfg_mode = 2'd1;
    tick();
    m_ptr = '0;
    check("t6_direct_armed", {29'd0, state_o}, {29'd0, ST_ARMED});
    sample(12'd0, 1'b1);
    sample(12'd3000, 1'b1);
    check("t6_post", {29'd0, state_o}, {29'd0, ST_POST});
    sample(12'd3001, 1'b1);
    rst = 1'b1;
    bus.adc_clk_en = 1'b1;
    tick();
    bus.adc_clk_en = 1'b0;
    check("t6_rst_idle", {29'd0, state_o}, {29'd0, ST_IDLE});
    check("t6_rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
    check("t6_rst_done", {31'd0, bus.frame_done}, 32'd0);
    check("t6_rst_rd_bank", {31'd0, bus.rd_bank}, 32'd1);
    cfg_mode = 2'd3;
    rst = 1'b0;
    tick();
    m_bank = 1'b0;
    cfg_mode = 2'd1;
    tick();
    m_ptr = '0;
    sample(12'd7, 1'b1);
    cfg_mode = 2'd3;
    repeat (2) tick();
    check("t6_idle_end", {29'd0, state_o}, {29'd0, ST_IDLE});
    check("t6_fd_cnt", fd_cnt, 32'd3);
    check("sb_empty", sbq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
